seq_hit_framer: RTL and testbench

Downstream consumer of the serial 1011 sequence detector's one-cycle match strobe. Groups the detector's bit stream into fixed frames of FRAME_LEN bit times. Counts matches per frame, optionally records the position of the first match, and delivers one result per frame over a valid/ready handshake. Frames that close while a previous result is still undelivered are dropped and flagged.

---
 rtl/seq_det_pkg.sv | 20 ++
 rtl/seq_frame_accum.sv | 74 +++++++
 rtl/seq_hit_framer.sv | 103 ++++++++++
 tb/tb_seq_hit_framer.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and helpers for the 1011 detector hit framer.
// Holds the output FSM state encoding and a saturating incrementer.
package seq_det_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } out_state_t;

    // Increment v, clamping at the all-ones value of a w-bit field.
    function automatic logic [31:0] sat_inc(
        input logic [31:0] v,
        input int          w
    );
        logic [31:0] maxv;
        maxv = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        return (v >= maxv) ? maxv : v + 32'd1;
    endfunction

endpackage

// File: rtl/seq_frame_accum.sv
// Frame position counter and per-frame match accumulator.
// First-match tracking exists only when SEQ_HIT_FIRST_EN is defined.
module seq_frame_accum
    import seq_det_pkg::*;
#(
    parameter int FRAME_LEN = 64,
    parameter int CNT_W     = 8,
    parameter int PW        = $clog2(FRAME_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_en,
    input  logic             hit,
    output logic             frame_close,
    output logic [CNT_W-1:0] res_cnt,
    output logic [PW-1:0]    res_first
);

    localparam logic [PW-1:0] LAST = PW'(FRAME_LEN - 1);

    logic [PW-1:0]    pos;
    logic [CNT_W-1:0] acc_cnt;
    logic             take;

    assign take        = bit_en & hit;
    assign frame_close = bit_en && (pos == LAST);

    // The closing cycle's own hit is folded into the frame result.
    assign res_cnt = take ? CNT_W'(sat_inc(32'(acc_cnt), CNT_W)) : acc_cnt;

    // Position advances per consumed bit and wraps at the frame end.
    always_ff @(posedge clk) begin
        if (rst) begin
            pos <= '0;
        end else if (bit_en) begin
            pos <= frame_close ? '0 : pos + 1'b1;
        end
    end

    // Match count accumulates within a frame and clears at frame close.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_cnt <= '0;
        end else if (frame_close) begin
            acc_cnt <= '0;
        end else if (take) begin
            acc_cnt <= res_cnt;
        end
    end

`ifdef SEQ_HIT_FIRST_EN
    logic [PW-1:0] acc_first;
    logic          seen;

    assign res_first = seen ? acc_first : (take ? pos : '0);

    // Capture the position of the first hit of the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_first <= '0;
            seen      <= 1'b0;
        end else if (frame_close) begin
            acc_first <= '0;
            seen      <= 1'b0;
        end else if (take && !seen) begin
            acc_first <= pos;
            seen      <= 1'b1;
        end
    end
`else
    assign res_first = '0;
`endif

endmodule

// File: rtl/seq_hit_framer.sv
// Frames the 1011 detector strobe and hands one result per frame downstream.
// Define SEQ_HIT_FIRST_EN to report the first-match position on out_first.
module seq_hit_framer
    import seq_det_pkg::*;
#(
    parameter int FRAME_LEN = 64,
    parameter int CNT_W     = 8,
    parameter int PW        = $clog2(FRAME_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_en,
    input  logic             hit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic [PW-1:0]    out_first,
    output logic             out_dropped
);

    out_state_t       state;
    out_state_t       state_nx;
    logic             frame_close;
    logic [CNT_W-1:0] res_cnt;
    logic [PW-1:0]    res_first;
    logic             load;
    logic             drop;
    logic             drop_pend;

    seq_frame_accum #(
        .FRAME_LEN(FRAME_LEN),
        .CNT_W    (CNT_W),
        .PW       (PW)
    ) u_accum (
        .clk        (clk),
        .rst        (rst),
        .bit_en     (bit_en),
        .hit        (hit),
        .frame_close(frame_close),
        .res_cnt    (res_cnt),
        .res_first  (res_first)
    );

    // Output FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= EMPTY;
        end else begin
            state <= state_nx;
        end
    end

    // Stay in HOLD while a result is pending or refilled on the same edge.
    always_comb begin
        state_nx = state;
        unique case (state)
            EMPTY: if (frame_close) state_nx = HOLD;
            HOLD:  if (out_ready && !frame_close) state_nx = EMPTY;
            default: state_nx = EMPTY;
        endcase
    end

    // A closing frame loads if the slot is free or being drained, else drops.
    always_comb begin
        load = 1'b0;
        drop = 1'b0;
        unique case (state)
            EMPTY: load = frame_close;
            HOLD: begin
                load = frame_close & out_ready;
                drop = frame_close & ~out_ready;
            end
            default: ;
        endcase
    end

    assign out_valid = (state == HOLD);

    // Result registers only change on a load, so they hold under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_count   <= '0;
            out_first   <= '0;
            out_dropped <= 1'b0;
        end else if (load) begin
            out_count   <= res_cnt;
            out_first   <= res_first;
            out_dropped <= drop_pend;
        end
    end

    // Remember a discarded frame until the next result carries the flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_pend <= 1'b0;
        end else if (load) begin
            drop_pend <= 1'b0;
        end else if (drop) begin
            drop_pend <= 1'b1;
        end
    end

endmodule

// File: tb/tb_seq_hit_framer.sv
// Scoreboard bench for seq_hit_framer, FRAME_LEN=8, CNT_W=8 and CNT_W=2.
// Expected out_first follows SEQ_HIT_FIRST_EN.
module tb_seq_hit_framer;

`ifdef SEQ_HIT_FIRST_EN
    localparam int FE = 1;
`else
    localparam int FE = 0;
`endif

    typedef struct {
        int c8;
        int c2;
        int f;
        int d;
    } res_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       bit_en = 1'b0;
    logic       hit = 1'b0;
    logic       out_ready = 1'b1;
    logic       v8, v2, d8, d2;
    logic [7:0] c8;
    logic [1:0] c2;
    logic [2:0] f8, f2;

    int n_chk = 0;
    int n_fail = 0;

    res_t q[$];
    res_t deliv[$];

    int   mpos = 0, mc8 = 0, mc2 = 0, mfirst = 0;
    bit   mseen = 0, mvalid = 0, mdp = 0;
    bit   hold_prev = 0;
    res_t snap;

    always #5 clk = ~clk;

    seq_hit_framer #(.FRAME_LEN(8), .CNT_W(8)) u8 (
        .clk(clk), .rst(rst), .bit_en(bit_en), .hit(hit),
        .out_valid(v8), .out_ready(out_ready), .out_count(c8),
        .out_first(f8), .out_dropped(d8)
    );

    seq_hit_framer #(.FRAME_LEN(8), .CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .bit_en(bit_en), .hit(hit),
        .out_valid(v2), .out_ready(out_ready), .out_count(c2),
        .out_first(f2), .out_dropped(d2)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Monitor and reference model; inputs seen here apply at the next edge.
    always @(negedge clk) begin
        bit   close, take;
        int   n8, n2, nf;
        res_t r;
        if (rst) begin
            mpos = 0; mc8 = 0; mc2 = 0; mfirst = 0;
            mseen = 0; mvalid = 0; mdp = 0; hold_prev = 0;
            q.delete();
        end else begin
            chk("valid8", 32'(v8), 32'(mvalid));
            chk("valid2", 32'(v2), 32'(mvalid));
            if (hold_prev) begin
                chk("stable_cnt", 32'(c8), 32'(snap.c8));
                chk("stable_first", 32'(f8), 32'(snap.f));
                chk("stable_drop", 32'(d8), 32'(snap.d));
            end
            if (mvalid && out_ready) begin
                if (q.size() == 0) begin
                    chk("sb_underflow", 32'(q.size()), 32'd1);
                end else begin
                    r = q.pop_front();
                    chk("cnt8", 32'(c8), 32'(r.c8));
                    chk("cnt2", 32'(c2), 32'(r.c2));
                    chk("first8", 32'(f8), 32'(r.f));
                    chk("first2", 32'(f2), 32'(r.f));
                    chk("drop8", 32'(d8), 32'(r.d));
                    chk("drop2", 32'(d2), 32'(r.d));
                    deliv.push_back('{int'(c8), int'(c2), int'(f8), int'(d8)});
                end
            end
            hold_prev = mvalid && !out_ready;
            snap = '{int'(c8), int'(c2), int'(f8), int'(d8)};
            close = bit_en && (mpos == 7);
            take = bit_en && hit;
            n8 = take ? ((mc8 >= 255) ? 255 : mc8 + 1) : mc8;
            n2 = take ? ((mc2 >= 3) ? 3 : mc2 + 1) : mc2;
            nf = mseen ? mfirst : (take ? mpos : 0);
            if (close) begin
                if (!mvalid || out_ready) begin
                    q.push_back('{n8, n2, (FE != 0) ? nf : 0, int'(mdp)});
                    mvalid = 1;
                    mdp = 0;
                end else begin
                    mdp = 1;
                end
                mc8 = 0; mc2 = 0; mfirst = 0; mseen = 0; mpos = 0;
            end else begin
                if (mvalid && out_ready) mvalid = 0;
                if (bit_en) begin
                    mc8 = n8;
                    mc2 = n2;
                    if (take && !mseen) begin
                        mseen = 1;
                        mfirst = mpos;
                    end
                    mpos = mpos + 1;
                end
            end
        end
    end

    task automatic step(input logic e, input logic h, input logic r);
        bit_en = e;
        hit = h;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic frame(input logic [7:0] hits, input logic r);
        for (int i = 0; i < 8; i++) step(1'b1, hits[i], r);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
    endtask

    task automatic chk_del(input string tag, input int idx, input int e8,
                           input int e2, input int ef, input int ed);
        if (deliv.size() > idx) begin
            chk({tag, "_cnt8"}, 32'(deliv[idx].c8), 32'(e8));
            chk({tag, "_cnt2"}, 32'(deliv[idx].c2), 32'(e2));
            chk({tag, "_first"}, 32'(deliv[idx].f), 32'((FE != 0) ? ef : 0));
            chk({tag, "_drop"}, 32'(deliv[idx].d), 32'(ed));
        end else begin
            chk({tag, "_present"}, 32'(deliv.size()), 32'(idx + 1));
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, {30'd0, v8, v2}, 32'd0);
        chk({tag, "_cnt"}, {22'd0, c8, c2}, 32'd0);
        chk({tag, "_first"}, {26'd0, f8, f2}, 32'd0);
        chk({tag, "_drop"}, {30'd0, d8, d2}, 32'd0);
    endtask

    initial begin
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        chk_zero("reset");
        rst = 1'b0;

        deliv.delete();
        frame(8'b0010_0100, 1'b1);
        idle(2);
        chk("s1_n", 32'(deliv.size()), 32'd1);
        chk_del("s1", 0, 2, 2, 2, 0);

        deliv.delete();
        frame(8'b1000_0000, 1'b1);
        idle(2);
        chk_del("s2", 0, 1, 1, 7, 0);

        deliv.delete();
        frame(8'hFF, 1'b1);
        for (int i = 0; i < 16; i++) step(1'((i + 1) % 2), 1'b1, 1'b1);
        idle(2);
        chk_del("s3_sat", 0, 8, 3, 0, 0);
        chk_del("s3_en", 1, 8, 3, 0, 0);

        deliv.delete();
        frame(8'b0000_0010, 1'b0);
        frame(8'b0000_1010, 1'b0);
        frame(8'b0101_0001, 1'b1);
        idle(2);
        chk("s4_n", 32'(deliv.size()), 32'd2);
        chk_del("s4_f1", 0, 1, 1, 1, 0);
        chk_del("s4_f3", 1, 3, 3, 0, 1);

        deliv.delete();
        frame(8'b0000_0100, 1'b0);
        for (int i = 0; i < 7; i++) step(1'b1, 1'(i == 1 || i == 3), 1'b0);
        step(1'b1, 1'b0, 1'b1);
        chk("s5_valid", 32'(v8), 32'd1);
        chk("s5_cnt", 32'(c8), 32'd2);
        chk("s5_drop", 32'(d8), 32'd0);
        idle(2);
        chk_del("s5_f1", 0, 1, 1, 2, 0);
        chk_del("s5_f2", 1, 2, 2, 1, 0);

        deliv.delete();
        for (int i = 0; i < 5; i++) step(1'b1, 1'(i == 3), 1'b1);
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b1);
        rst = 1'b0;
        chk_zero("s6_rst");
        frame(8'b0100_0001, 1'b1);
        chk("s6_valid", 32'(v8), 32'd1);
        idle(2);
        chk("s6_n", 32'(deliv.size()), 32'd1);
        chk_del("s6", 0, 2, 2, 0, 0);

        chk("sb_drain", 32'(q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
